// File: rtl/tx_sched_pkg.sv
// Shared types and symbol constants for the TX symbol scheduler.
package tx_sched_pkg;

  localparam int unsigned SYM_W          = 8;
  localparam int unsigned SKP_CNT_W      = 12;
  localparam int unsigned OS_CNT_W       = 3;
  localparam int unsigned EIOS_IDL_COUNT = 3;

  localparam logic [SYM_W-1:0] K28_5 = 8'hBC;
  localparam logic [SYM_W-1:0] K28_0 = 8'h1C;
  localparam logic [SYM_W-1:0] K28_3 = 8'h7C;
  localparam logic [SYM_W-1:0] LIDLE = 8'h00;

  typedef enum logic [2:0] {
    DISABLED,
    FILL,
    DATA,
    SKP_COM,
    SKP_SYM,
    EIOS_COM,
    EIOS_IDL,
    EIDLE
  } state_e;

  typedef struct packed {
    logic             k;
    logic [SYM_W-1:0] data;
  } sym_t;

endpackage

// File: rtl/skp_interval_counter.sv
// Counts emitted symbols since the last SKP COM and raises a sticky skp_due.
module skp_interval_counter
  import tx_sched_pkg::*;
#(
  parameter int unsigned SKP_INTERVAL = 1180
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic skp_due
);

  localparam logic [SKP_CNT_W-1:0] DUE_AT  = SKP_CNT_W'(SKP_INTERVAL - 1);
  localparam logic [SKP_CNT_W-1:0] CNT_MAX = '1;

  logic [SKP_CNT_W-1:0] cnt_q, cnt_d;
  logic                 due_q, due_d;
  logic                 com_c;

  // inc together with clr only happens when a SKP COM is emitted; clr alone is DISABLED/EIDLE
  always_comb begin
    com_c = inc && clr;
    cnt_d = cnt_q;
    due_d = due_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + SKP_CNT_W'(1);
    end
    if (com_c) begin
      due_d = 1'b0;
    end else if (cnt_d == DUE_AT) begin
      due_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      due_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      due_q <= due_d;
    end
  end

  assign skp_due = due_q;

endmodule

// File: rtl/tx_symbol_scheduler.sv
// Per-symbol selection between user data, SKP, EIOS and logical idle ahead of the 8b/10b encoder.
module tx_symbol_scheduler
  import tx_sched_pkg::*;
#(
  parameter int unsigned SKP_INTERVAL = 1180,
  parameter int unsigned SKP_COUNT    = 3
) (
  input  logic             Bit_Rate_10,
  input  logic             Rst,
  input  logic             enable,
  input  logic [SYM_W-1:0] tx_data,
  input  logic             tx_datak,
  input  logic             tx_valid,
  input  logic             tx_last,
  output logic             tx_ready,
  input  logic             eidle_req,
  output logic [SYM_W-1:0] sym_out,
  output logic             symk_out,
  output logic             enable_encoder,
  output logic             underrun,
  output logic             in_eidle
);

  state_e                state_q, state_d;
  logic [OS_CNT_W-1:0]   os_cnt_q, os_cnt_d;
  logic                  skp_due;
  logic                  tx_ready_c;
  logic                  accept_c;

  sym_t sym_q, sym_d;
  logic enc_q, enc_d;
  logic underrun_q, underrun_d;
  logic in_eidle_q, in_eidle_d;
  logic cnt_inc, cnt_clr;

  assign tx_ready_c = enable && (((state_q == FILL) && !eidle_req && !skp_due) ||
                                 (state_q == DATA));
  assign accept_c   = tx_valid && tx_ready_c;

  always_ff @(posedge Bit_Rate_10 or negedge Rst) begin
    if (!Rst) begin
      state_q  <= DISABLED;
      os_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      os_cnt_q <= os_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    os_cnt_d = '0;
    if (!enable) begin
      state_d = DISABLED;
    end else begin
      case (state_q)
        DISABLED: state_d = FILL;
        FILL: begin
          if (eidle_req)                  state_d = EIOS_COM;
          else if (skp_due)               state_d = SKP_COM;
          else if (tx_valid && !tx_last)  state_d = DATA;
        end
        DATA:     if (tx_valid && tx_last) state_d = FILL;
        SKP_COM:  state_d = SKP_SYM;
        SKP_SYM:  if (os_cnt_q == OS_CNT_W'(SKP_COUNT - 1)) state_d = FILL;
        EIOS_COM: state_d = EIOS_IDL;
        EIOS_IDL: if (os_cnt_q == OS_CNT_W'(EIOS_IDL_COUNT - 1)) state_d = EIDLE;
        EIDLE:    if (!eidle_req) state_d = FILL;
        default:  state_d = DISABLED;
      endcase
    end
    if (((state_q == SKP_SYM) || (state_q == EIOS_IDL)) && (state_d == state_q)) begin
      os_cnt_d = os_cnt_q + OS_CNT_W'(1);
    end
  end

  // The symbol launched on an edge belongs to the state being entered on that edge
  always_comb begin
    sym_d      = '0;
    enc_d      = 1'b0;
    underrun_d = 1'b0;
    in_eidle_d = 1'b0;
    case (state_d)
      FILL, DATA: begin
        enc_d      = 1'b1;
        sym_d      = accept_c ? sym_t'{k: tx_datak, data: tx_data} : sym_t'{k: 1'b0, data: LIDLE};
        underrun_d = (state_q == DATA) && !tx_valid;
      end
      SKP_COM, EIOS_COM: begin
        enc_d = 1'b1;
        sym_d = sym_t'{k: 1'b1, data: K28_5};
      end
      SKP_SYM: begin
        enc_d = 1'b1;
        sym_d = sym_t'{k: 1'b1, data: K28_0};
      end
      EIOS_IDL: begin
        enc_d = 1'b1;
        sym_d = sym_t'{k: 1'b1, data: K28_3};
      end
      EIDLE:    in_eidle_d = 1'b1;
      default: begin
        sym_d = '0;
      end
    endcase
    cnt_inc = enc_d;
    cnt_clr = (state_d == SKP_COM) || (state_d == DISABLED) || (state_d == EIDLE);
  end

  always_ff @(posedge Bit_Rate_10 or negedge Rst) begin
    if (!Rst) begin
      sym_q      <= '0;
      enc_q      <= 1'b0;
      underrun_q <= 1'b0;
      in_eidle_q <= 1'b0;
    end else begin
      sym_q      <= sym_d;
      enc_q      <= enc_d;
      underrun_q <= underrun_d;
      in_eidle_q <= in_eidle_d;
    end
  end

  skp_interval_counter #(
    .SKP_INTERVAL (SKP_INTERVAL)
  ) u_skp_cnt (
    .clk     (Bit_Rate_10),
    .rst_n   (Rst),
    .inc     (cnt_inc),
    .clr     (cnt_clr),
    .skp_due (skp_due)
  );

  assign tx_ready       = tx_ready_c;
  assign sym_out        = sym_q.data;
  assign symk_out       = sym_q.k;
  assign enable_encoder = enc_q;
  assign underrun       = underrun_q;
  assign in_eidle       = in_eidle_q;

endmodule

// File: tb/tb_tx_symbol_scheduler.sv
// Directed bench for tx_symbol_scheduler with SKP_INTERVAL=16, SKP_COUNT=3.
module tb_tx_symbol_scheduler;

  logic       Bit_Rate_10;
  logic       Rst;
  logic       enable;
  logic [7:0] tx_data;
  logic       tx_datak;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;
  logic       eidle_req;
  logic [7:0] sym_out;
  logic       symk_out;
  logic       enable_encoder;
  logic       underrun;
  logic       in_eidle;

  int n_tests = 0;
  int n_fail  = 0;

  tx_symbol_scheduler #(
    .SKP_INTERVAL (16),
    .SKP_COUNT    (3)
  ) dut (
    .Bit_Rate_10    (Bit_Rate_10),
    .Rst            (Rst),
    .enable         (enable),
    .tx_data        (tx_data),
    .tx_datak       (tx_datak),
    .tx_valid       (tx_valid),
    .tx_last        (tx_last),
    .tx_ready       (tx_ready),
    .eidle_req      (eidle_req),
    .sym_out        (sym_out),
    .symk_out       (symk_out),
    .enable_encoder (enable_encoder),
    .underrun       (underrun),
    .in_eidle       (in_eidle)
  );

  initial Bit_Rate_10 = 1'b0;
  always #5 Bit_Rate_10 = ~Bit_Rate_10;

  task automatic tick();
    @(posedge Bit_Rate_10);
    #1;
  endtask

  task automatic do_reset();
    Rst = 1'b0; enable = 1'b1; tx_valid = 1'b0; tx_last = 1'b0;
    tx_data = 8'h00; tx_datak = 1'b0; eidle_req = 1'b0;
    tick();
    tick();
    Rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [12:0] obs;
    Rst = 1'b0; enable = 1'b1; tx_valid = 1'b0; tx_last = 1'b0;
    tx_data = 8'h00; tx_datak = 1'b0; eidle_req = 1'b0;
    tick();
    tick();
    obs = {sym_out, symk_out, enable_encoder, underrun, in_eidle, tx_ready};
    n_tests++;
    if (obs !== 13'h0) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected %h", obs, 13'h0);
    end
    Rst = 1'b1;
    tick();
    n_tests++;
    if (enable_encoder !== 1'b1 || sym_out !== 8'h00) begin
      n_fail++; $display("FAIL reset_first_sym: got enc=%b sym=%h expected enc=1 sym=00", enable_encoder, sym_out);
    end
    tick();
    n_tests++;
    if ({sym_out, symk_out, enable_encoder} !== {8'h00, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL reset_idle: got sym=%h k=%b enc=%b expected 00 0 1", sym_out, symk_out, enable_encoder);
    end
    n_tests++;
    if (tx_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b expected 1", tx_ready);
    end
  endtask

  task automatic test_packet();
    logic [7:0] pkt [3];
    pkt[0] = 8'h11; pkt[1] = 8'h22; pkt[2] = 8'h33;
    do_reset();
    tick();
    for (int i = 0; i < 3; i++) begin
      tx_valid = 1'b1; tx_data = pkt[i]; tx_datak = 1'b0; tx_last = (i == 2);
      #1;
      n_tests++;
      if (tx_ready !== 1'b1) begin
        n_fail++; $display("FAIL pkt_ready%0d: got %b expected 1", i, tx_ready);
      end
      tick();
      n_tests++;
      if ({symk_out, sym_out} !== {1'b0, pkt[i]}) begin
        n_fail++; $display("FAIL pkt_sym%0d: got k=%b sym=%h expected k=0 sym=%h", i, symk_out, sym_out, pkt[i]);
      end
    end
    tx_valid = 1'b0; tx_last = 1'b0;
    tick();
    n_tests++;
    if ({symk_out, sym_out} !== 9'h000) begin
      n_fail++; $display("FAIL pkt_after_idle: got k=%b sym=%h expected k=0 sym=00", symk_out, sym_out);
    end
  endtask

  task automatic test_skp_idle();
    logic [7:0] s [1:50];
    logic       k [1:50];
    logic       r [1:50];
    int         n_com;
    do_reset();
    for (int i = 1; i <= 50; i++) begin
      tick();
      s[i] = sym_out; k[i] = symk_out; r[i] = tx_ready;
    end
    n_tests++;
    if ({k[16], s[16]} !== {1'b1, 8'hBC}) begin
      n_fail++; $display("FAIL skp_com1: got k=%b sym=%h expected k=1 sym=bc", k[16], s[16]);
    end
    for (int i = 17; i <= 19; i++) begin
      n_tests++;
      if ({k[i], s[i]} !== {1'b1, 8'h1C}) begin
        n_fail++; $display("FAIL skp_sym%0d: got k=%b sym=%h expected k=1 sym=1c", i, k[i], s[i]);
      end
    end
    n_tests++;
    if ({k[20], s[20]} !== 9'h000) begin
      n_fail++; $display("FAIL skp_end_idle: got k=%b sym=%h expected k=0 sym=00", k[20], s[20]);
    end
    n_tests++;
    if ({k[32], s[32], k[33], s[33]} !== {1'b1, 8'hBC, 1'b1, 8'h1C}) begin
      n_fail++; $display("FAIL skp_com2: got %h %h expected bc 1c", s[32], s[33]);
    end
    n_tests++;
    if ({k[48], s[48]} !== {1'b1, 8'hBC}) begin
      n_fail++; $display("FAIL skp_com3: got k=%b sym=%h expected k=1 sym=bc", k[48], s[48]);
    end
    n_com = 0;
    for (int i = 1; i <= 50; i++) if (s[i] == 8'hBC) n_com++;
    n_tests++;
    if (n_com !== 3) begin
      n_fail++; $display("FAIL skp_com_count: got %0d expected 3", n_com);
    end
    n_tests++;
    if ({r[14], r[15], r[20]} !== 3'b101) begin
      n_fail++; $display("FAIL skp_ready: got %b%b%b expected 101", r[14], r[15], r[20]);
    end
  endtask

  task automatic test_skp_deferred();
    do_reset();
    repeat (5) tick();
    for (int i = 0; i < 20; i++) begin
      tx_valid = 1'b1; tx_data = 8'h40 + 8'(i); tx_datak = 1'b0; tx_last = (i == 19);
      #1;
      if (i == 10) begin
        n_tests++;
        if (tx_ready !== 1'b1) begin
          n_fail++; $display("FAIL defer_ready: got %b expected 1", tx_ready);
        end
      end
      tick();
      n_tests++;
      if (sym_out !== 8'h40 + 8'(i)) begin
        n_fail++; $display("FAIL defer_sym%0d: got %h expected %h", i, sym_out, 8'h40 + 8'(i));
      end
    end
    tx_valid = 1'b0; tx_last = 1'b0;
    tick();
    n_tests++;
    if ({symk_out, sym_out} !== {1'b1, 8'hBC}) begin
      n_fail++; $display("FAIL defer_com: got k=%b sym=%h expected k=1 sym=bc", symk_out, sym_out);
    end
    tick();
    n_tests++;
    if ({symk_out, sym_out} !== {1'b1, 8'h1C}) begin
      n_fail++; $display("FAIL defer_skp: got k=%b sym=%h expected k=1 sym=1c", symk_out, sym_out);
    end
  endtask

  task automatic test_eidle();
    do_reset();
    tick();
    eidle_req = 1'b1;
    #1;
    n_tests++;
    if (tx_ready !== 1'b0) begin
      n_fail++; $display("FAIL eidle_ready: got %b expected 0", tx_ready);
    end
    for (int j = 1; j <= 10; j++) begin
      tick();
      if (j == 1) begin
        n_tests++;
        if ({enable_encoder, symk_out, sym_out} !== {1'b1, 1'b1, 8'hBC}) begin
          n_fail++; $display("FAIL eios_com: got enc=%b k=%b sym=%h expected 1 1 bc", enable_encoder, symk_out, sym_out);
        end
      end else if (j <= 4) begin
        n_tests++;
        if ({symk_out, sym_out} !== {1'b1, 8'h7C}) begin
          n_fail++; $display("FAIL eios_idl%0d: got k=%b sym=%h expected k=1 sym=7c", j, symk_out, sym_out);
        end
      end else if (j == 5 || j == 10) begin
        n_tests++;
        if ({enable_encoder, in_eidle, sym_out} !== {1'b0, 1'b1, 8'h00}) begin
          n_fail++; $display("FAIL eidle_hold%0d: got enc=%b eidle=%b sym=%h expected 0 1 00", j, enable_encoder, in_eidle, sym_out);
        end
      end
    end
    eidle_req = 1'b0;
    tick();
    n_tests++;
    if ({enable_encoder, in_eidle, symk_out, sym_out} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
      n_fail++; $display("FAIL eidle_exit: got enc=%b eidle=%b k=%b sym=%h expected 1 0 0 00", enable_encoder, in_eidle, symk_out, sym_out);
    end
  endtask

  task automatic test_eidle_skp();
    do_reset();
    repeat (15) tick();
    eidle_req = 1'b1;
    tick();
    n_tests++;
    if (sym_out !== 8'hBC) begin
      n_fail++; $display("FAIL both_com: got %h expected bc", sym_out);
    end
    tick();
    n_tests++;
    if (sym_out !== 8'h7C) begin
      n_fail++; $display("FAIL both_eios_first: got %h expected 7c", sym_out);
    end
    repeat (4) tick();
    eidle_req = 1'b0;
    tick();
    n_tests++;
    if ({enable_encoder, sym_out} !== {1'b1, 8'h00}) begin
      n_fail++; $display("FAIL both_exit: got enc=%b sym=%h expected 1 00", enable_encoder, sym_out);
    end
    tick();
    n_tests++;
    if ({symk_out, sym_out} !== {1'b1, 8'hBC}) begin
      n_fail++; $display("FAIL both_skp_kept: got k=%b sym=%h expected k=1 sym=bc", symk_out, sym_out);
    end
    tick();
    n_tests++;
    if (sym_out !== 8'h1C) begin
      n_fail++; $display("FAIL both_skp_sym: got %h expected 1c", sym_out);
    end
  endtask

  task automatic test_underrun();
    do_reset();
    tick();
    tx_valid = 1'b1; tx_data = 8'hA1; tx_last = 1'b0;
    tick();
    n_tests++;
    if ({sym_out, underrun} !== {8'hA1, 1'b0}) begin
      n_fail++; $display("FAIL ur_first: got sym=%h ur=%b expected a1 0", sym_out, underrun);
    end
    tx_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_tests++;
      if (tx_ready !== 1'b1) begin
        n_fail++; $display("FAIL ur_ready%0d: got %b expected 1", i, tx_ready);
      end
      tick();
      n_tests++;
      if ({sym_out, symk_out, underrun} !== {8'h00, 1'b0, 1'b1}) begin
        n_fail++; $display("FAIL ur_gap%0d: got sym=%h k=%b ur=%b expected 00 0 1", i, sym_out, symk_out, underrun);
      end
    end
    tx_valid = 1'b1; tx_data = 8'hA2; tx_last = 1'b1;
    tick();
    n_tests++;
    if ({sym_out, underrun} !== {8'hA2, 1'b0}) begin
      n_fail++; $display("FAIL ur_last: got sym=%h ur=%b expected a2 0", sym_out, underrun);
    end
    tx_valid = 1'b0; tx_last = 1'b0;
  endtask

  task automatic test_disable_skp();
    do_reset();
    repeat (16) tick();
    n_tests++;
    if (sym_out !== 8'hBC) begin
      n_fail++; $display("FAIL dis_com: got %h expected bc", sym_out);
    end
    tick();
    enable = 1'b0;
    tick();
    n_tests++;
    if ({sym_out, symk_out, enable_encoder} !== 10'h0) begin
      n_fail++; $display("FAIL dis_zero: got sym=%h k=%b enc=%b expected 00 0 0", sym_out, symk_out, enable_encoder);
    end
    enable = 1'b1;
    #1;
    n_tests++;
    if (tx_ready !== 1'b0) begin
      n_fail++; $display("FAIL dis_state: got ready=%b expected 0", tx_ready);
    end
    tick();
    n_tests++;
    if ({enable_encoder, symk_out, sym_out} !== {1'b1, 1'b0, 8'h00}) begin
      n_fail++; $display("FAIL dis_resume: got enc=%b k=%b sym=%h expected 1 0 00", enable_encoder, symk_out, sym_out);
    end
  endtask

  initial begin
    test_reset();
    test_packet();
    test_skp_idle();
    test_skp_deferred();
    test_eidle();
    test_eidle_skp();
    test_underrun();
    test_disable_skp();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_symbol_scheduler.md
# tx_symbol_scheduler

Symbol-rate scheduler in front of the TX 8b/10b encoder and running-disparity stage. Each symbol clock it picks one 8-bit symbol plus its K flag from four sources: user packet data (valid/ready), periodic SKP ordered sets, the Electrical Idle ordered set (EIOS), and logical-idle filler. It also drives the encoder/PMA enable, so the running-disparity FSM sees a gap-free, correctly ordered symbol stream.

## Interface
- SKP_INTERVAL, 1180, symbols between SKP ordered-set starts; legal range 16..4095
- SKP_COUNT, 3, SKP symbols after COM; legal range 1..5
- Bit_Rate_10  in  1  symbol clock, rising edge
- Rst  in  1  reset, asynchronous, active-low
- enable  in  1  scheduler enable; low forces state DISABLED
- tx_data  in  8  user symbol
- tx_datak  in  1  user K flag
- tx_valid  in  1  user symbol valid
- tx_last  in  1  last symbol of a packet; qualified by tx_valid
- tx_ready  out  1  user symbol accepted this cycle when tx_valid&&tx_ready
- eidle_req  in  1  request to send EIOS and enter electrical idle; level
- sym_out  out  8  symbol to encoder
- symk_out  out  1  K flag to encoder
- enable_encoder  out  1  encoder/PMA enable
- underrun  out  1  one-cycle pulse: tx_valid low while in a packet
- in_eidle  out  1  high while electrical idle is held

## Operation
- States: DISABLED, FILL, DATA, SKP_COM, SKP_SYM, EIOS_COM, EIOS_IDL, EIDLE.
- Priority at packet boundaries (not in a packet): EIOS > SKP > user data > logical idle.
- DISABLED: entered on reset or whenever enable=0, from any state. Outputs are zero. Exit to FILL on the cycle enable=1 is sampled.
- FILL: if eidle_req, go to EIOS_COM. Else if skp_due, go to SKP_COM. Else if tx_valid, accept the symbol; go to DATA unless tx_last. Else emit logical idle (8'h00, K=0).
- DATA (in packet): accept user symbols only. tx_last returns to FILL. tx_valid=0 emits logical idle, pulses underrun and stays in DATA. SKP and EIOS wait until the packet ends.
- SKP_COM: emit K28.5 (8'hBC, K=1), then go to SKP_SYM. SKP_SYM: emit K28.0 (8'h1C, K=1) SKP_COUNT times, then go to FILL.
- EIOS_COM: emit K28.5, then go to EIOS_IDL. EIOS_IDL: emit K28.3 (8'h7C, K=1) three times, then go to EIDLE.
- EIDLE: enable_encoder=0, sym_out=0, in_eidle=1. Exit to FILL on the first cycle eidle_req=0.
- SKP counter (12 bits):
  - Increments on every emitted symbol.
  - Clears on emission of a SKP COM.
  - Sets skp_due at SKP_INTERVAL-1 and holds it until the SKP COM is emitted.
  - Saturates rather than wrapping.
  - Clears in DISABLED and EIDLE.
- tx_ready is combinational: enable && ((state==FILL && !eidle_req && !skp_due) || state==DATA).

## Timing
- Reset values: all outputs 0, state DISABLED, counter 0, skp_due 0.
- sym_out, symk_out, enable_encoder, underrun and in_eidle are registered. An accepted symbol appears on sym_out exactly 1 cycle after the tx_valid&&tx_ready edge.
- enable_encoder is 1 in FILL, DATA, SKP_* and EIOS_*. It rises on the same cycle as the first valid sym_out after DISABLED or EIDLE.
- Symbol latencies:
  - SKP ordered set: 1+SKP_COUNT consecutive cycles.
  - EIOS: 4 consecutive cycles.
  - Neither is ever interrupted except by enable=0 or Rst.
- skp_due and eidle_req asserted on the same cycle: EIOS is sent first. skp_due is kept and honoured first after EIDLE exits, because the counter clears in EIDLE but skp_due is not cleared there.
- enable=0 mid-ordered-set or mid-packet: abort immediately. Next cycle outputs are zero. The packet state is discarded.
- tx_last on a symbol with skp_due high: the SKP COM follows on the very next symbol.

## Structure
- Package tx_sched_pkg holds:
  - state enum
  - symbol constants: K28_5=8'hBC, K28_0=8'h1C, K28_3=8'h7C, LIDLE=8'h00
  - EIOS_IDL_COUNT=3
- Sub-module skp_interval_counter (parameter SKP_INTERVAL):
  - inputs: inc, clr
  - output: skp_due

## Test plan
- Reset with enable=1 and no traffic: after Rst releases, the second cycle shows sym_out=8'h00, symk_out=0, enable_encoder=1. tx_ready=1.
- Packet 8'h11,8'h22,8'h33 with tx_last on 8'h33, tx_valid held: sym_out shows 11,22,33 on consecutive cycles, each 1 cycle after acceptance. Then 8'h00.
- SKP_INTERVAL=16, SKP_COUNT=3, idle link: BC,1C,1C,1C appears with COM starts 16 symbols apart. tx_ready=0 while skp_due.
- skp_due rises mid-packet of 20 symbols: SKP is deferred. BC is emitted directly after the tx_last symbol.
- eidle_req pulse held 10 cycles from FILL: outputs BC,7C,7C,7C then enable_encoder=0 and in_eidle=1. After eidle_req falls, logical idle resumes.
- tx_valid dropped for 2 cycles mid-packet: two 8'h00 symbols and two underrun pulses. enable=0 during an SKP ordered set: outputs are zero the next cycle and state is DISABLED.
